// File: rtl/trash_pkg.sv
// Shared encodings for the trash_cpu slice: opcodes, ALU operations and instruction field positions.
package trash_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JNZ  = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOT = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;
  localparam logic [3:0] ALU_SHL = 4'h7;
  localparam logic [3:0] ALU_INC = 4'h8;
  localparam logic [3:0] ALU_DEC = 4'h9;
  localparam logic [3:0] ALU_MUL = 4'hA;
  localparam logic [3:0] ALU_MOV = 4'hB;

  localparam int OPC_LSB = 12;
  localparam int A_LSB   = 8;
  localparam int B_LSB   = 4;
  localparam int C_LSB   = 0;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

endpackage

// File: rtl/trash_alu.sv
// Combinational ALU, zero latency, no handshake; x is the destination operand, y the source.
// Results wrap to DATA_W; reserved ops pass x through so the destination is left unchanged.
module trash_alu
  import trash_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] res
);

  always_comb begin
    res = x;
    case (op)
      ALU_ADD: res = x + y;
      ALU_SUB: res = x - y;
      ALU_AND: res = x & y;
      ALU_OR:  res = x | y;
      ALU_XOR: res = x ^ y;
      ALU_NOT: res = ~x;
      ALU_SHR: res = x >> 1;
      ALU_SHL: res = x << 1;
      ALU_INC: res = x + DATA_W'(1);
      ALU_DEC: res = x - DATA_W'(1);
      ALU_MUL: res = x * y;
      ALU_MOV: res = y;
      default: res = x;
    endcase
  end

endmodule

// File: rtl/trash_cpu.sv
// Accumulator micro-CPU: host loads program words while idle/halted, then start runs FETCH/EXEC at 2 cycles per instruction.
// No backpressure: out_valid is a single-cycle strobe and loads during a run are dropped.
module trash_cpu
  import trash_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NREGS      = 4,
  parameter int PROG_DEPTH = 16,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [15:0]                   load_word,
  input  logic                          start,
  output logic                          busy,
  output logic                          halted,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid
);

  localparam int PW = $clog2(PROG_DEPTH);
  localparam int MW = $clog2(MEM_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [PW-1:0]     load_addr_q, load_addr_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [15:0]       prog_q [PROG_DEPTH];
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] mem_q  [MEM_DEPTH];

  logic [3:0]         opc, fa, fb, fc;
  logic [IMM_W-1:0]   imm;
  logic [MW-1:0]      mem_addr;
  logic [DATA_W-1:0]  ra, rb, rc, alu_res;
  logic               prog_we, reg_we, mem_we;
  logic [3:0]         reg_wa;
  logic [DATA_W-1:0]  reg_wd;

  assign opc      = ir_q[OPC_LSB +: FIELD_W];
  assign fa       = ir_q[A_LSB +: FIELD_W];
  assign fb       = ir_q[B_LSB +: FIELD_W];
  assign fc       = ir_q[C_LSB +: FIELD_W];
  assign imm      = ir_q[IMM_W-1:0];
  assign mem_addr = fa[MW-1:0];

  // Indices at or above NREGS match no entry, so such reads return zero.
  always_comb begin
    ra = '0;
    rb = '0;
    rc = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (fa == 4'(i)) ra = regs_q[i];
      if (fb == 4'(i)) rb = regs_q[i];
      if (fc == 4'(i)) rc = regs_q[i];
    end
  end

  trash_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (fa),
    .x   (rb),
    .y   (rc),
    .res (alu_res)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_addr_d = load_addr_q;
    ir_d        = ir_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    prog_we     = 1'b0;
    reg_we      = 1'b0;
    reg_wa      = '0;
    reg_wd      = '0;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (load_valid) begin
          prog_we     = 1'b1;
          load_addr_d = load_addr_q + PW'(1);
        end else if (start) begin
          state_d     = S_FETCH;
          pc_d        = '0;
          load_addr_d = '0;
        end
      end
      S_FETCH: begin
        ir_d    = prog_q[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PW'(1);
        case (opc)
          OP_NOP: ;
          OP_LDI: begin
            reg_we = 1'b1;
            reg_wa = fa;
            reg_wd = DATA_W'(imm);
          end
          OP_ALU: begin
            reg_we = 1'b1;
            reg_wa = fb;
            reg_wd = alu_res;
          end
          OP_ST: mem_we = 1'b1;
          OP_LD: begin
            reg_we = 1'b1;
            reg_wa = fc;
            reg_wd = mem_q[mem_addr];
          end
          OP_JMP: pc_d = imm[PW-1:0];
          OP_JNZ: if (ra != '0) pc_d = imm[PW-1:0];
          OP_OUT: begin
            out_data_d  = ra;
            out_valid_d = 1'b1;
          end
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      load_addr_q <= '0;
      ir_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      load_addr_q <= load_addr_d;
      ir_q        <= ir_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < NREGS; i++) begin
        if (reg_we && reg_wa == 4'(i)) regs_q[i] <= reg_wd;
      end
      if (mem_we) mem_q[mem_addr] <= rc;
    end
  end

  // Program store survives reset so the host need not reload after a reset.
  always_ff @(posedge clk) begin
    if (prog_we && !reset) prog_q[load_addr_q] <= load_word;
  end

  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign pc        = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_trash_cpu.sv
// Directed bench: an 8-bit and a 12-bit trash_cpu share stimulus; program/expectation table plus corner sequences.
module tb_trash_cpu;

  logic        clk, reset, load_valid, start;
  logic [15:0] load_word;
  logic        busy8, halted8, ov8, busy12, halted12, ov12;
  logic [3:0]  pc8, pc12;
  logic [7:0]  od8;
  logic [11:0] od12;

  trash_cpu #(.DATA_W(8), .NREGS(4), .PROG_DEPTH(16), .MEM_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_word(load_word), .start(start),
    .busy(busy8), .halted(halted8), .pc(pc8), .out_data(od8), .out_valid(ov8));

  trash_cpu #(.DATA_W(12), .NREGS(4), .PROG_DEPTH(16), .MEM_DEPTH(16)) dut12 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_word(load_word), .start(start),
    .busy(busy12), .halted(halted12), .pc(pc12), .out_data(od12), .out_valid(ov12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pb;     // first program word in wq
    int pn;
    int ob;     // first expected output in e8q/e12q
    int on;
    int first;  // cycles after the start edge until the first out_valid is seen
    int halt;   // cycles after the start edge until halted is seen
  } vec_t;

  vec_t        vt[9];
  int          nv;
  logic [15:0] wq[$];
  logic [7:0]  e8q[$];
  logic [11:0] e12q[$];
  logic [7:0]  got8[$];
  logic [11:0] got12[$];
  int          first_cnt, halt_cnt, busy0;
  int          total, bad;

  localparam logic [15:0] HLT = 16'h8000;

  function automatic logic [15:0] ldi(input logic [3:0] a, input logic [7:0] v);
    return {4'h1, a, v};
  endfunction
  function automatic logic [15:0] alu(input logic [3:0] op, input logic [3:0] b, input logic [3:0] c);
    return {4'h2, op, b, c};
  endfunction
  function automatic logic [15:0] st(input logic [3:0] a, input logic [3:0] c);
    return {4'h3, a, 4'h0, c};
  endfunction
  function automatic logic [15:0] ld(input logic [3:0] a, input logic [3:0] c);
    return {4'h4, a, 4'h0, c};
  endfunction
  function automatic logic [15:0] jmp(input logic [7:0] v);
    return {4'h5, 4'h0, v};
  endfunction
  function automatic logic [15:0] jnz(input logic [3:0] a, input logic [7:0] v);
    return {4'h6, a, v};
  endfunction
  function automatic logic [15:0] outr(input logic [3:0] a);
    return {4'h7, a, 8'h00};
  endfunction

  task automatic w(input logic [15:0] x);
    wq.push_back(x);
  endtask
  task automatic e(input logic [7:0] v8, input logic [11:0] v12);
    e8q.push_back(v8);
    e12q.push_back(v12);
  endtask
  task automatic vbeg();
    vt[nv].pb = wq.size();
    vt[nv].ob = e8q.size();
  endtask
  task automatic vend(input int first, input int halt);
    vt[nv].pn    = wq.size() - vt[nv].pb;
    vt[nv].on    = e8q.size() - vt[nv].ob;
    vt[nv].first = first;
    vt[nv].halt  = halt;
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_prog(input int i);
    for (int k = 0; k < vt[i].pn; k++) begin
      load_valid = 1'b1;
      load_word  = wq[vt[i].pb + k];
      tick();
    end
    load_valid = 1'b0;
  endtask

  // poke drives load_valid for two cycles mid-run; a gated core must ignore it.
  task automatic run(input bit poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    got8.delete();
    got12.delete();
    first_cnt = -1;
    halt_cnt  = -1;
    busy0     = int'(busy8);
    for (int c = 0; c < 400; c++) begin
      if (poke) begin
        load_valid = (c == 3 || c == 4);
        load_word  = 16'h7100;
      end
      if (ov8) begin
        if (first_cnt < 0) first_cnt = c;
        got8.push_back(od8);
      end
      if (ov12) got12.push_back(od12);
      if (halted8) begin
        halt_cnt = c;
        break;
      end
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic check_vec(input int i, input string tag);
    chk($sformatf("%s.busy0", tag), busy0, 1);
    chk($sformatf("%s.first", tag), first_cnt, vt[i].first);
    chk($sformatf("%s.halt", tag), halt_cnt, vt[i].halt);
    chk($sformatf("%s.n8", tag), got8.size(), vt[i].on);
    chk($sformatf("%s.n12", tag), got12.size(), vt[i].on);
    for (int j = 0; j < vt[i].on; j++) begin
      chk($sformatf("%s.out8[%0d]", tag, j), (j < got8.size()) ? int'(got8[j]) : -1,
          int'(e8q[vt[i].ob + j]));
      chk($sformatf("%s.out12[%0d]", tag, j), (j < got12.size()) ? int'(got12[j]) : -1,
          int'(e12q[vt[i].ob + j]));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk($sformatf("%s.busy", tag), int'(busy8), 0);
    chk($sformatf("%s.halted", tag), int'(halted8), 0);
    chk($sformatf("%s.pc", tag), int'(pc8), 0);
    chk($sformatf("%s.out_data", tag), int'(od8), 0);
    chk($sformatf("%s.out_valid", tag), int'(ov8), 0);
    chk($sformatf("%s.busy12", tag), int'(busy12), 0);
    chk($sformatf("%s.out_data12", tag), int'(od12), 0);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; start = 1'b0; load_word = '0;
    total = 0; bad = 0; nv = 0;

    // v0 add
    vbeg(); w(ldi(4'd0, 8'd5)); w(ldi(4'd1, 8'd3)); w(alu(4'h0, 4'd0, 4'd1)); w(outr(4'd0)); w(HLT);
    e(8'h08, 12'h008); vend(8, 10);
    // v1 countdown loop
    vbeg(); w(ldi(4'd0, 8'd3)); w(alu(4'h9, 4'd0, 4'd0)); w(outr(4'd0)); w(jnz(4'd0, 8'd1)); w(HLT);
    e(8'h02, 12'h002); e(8'h01, 12'h001); e(8'h00, 12'h000); vend(6, 22);
    // v2 increment wrap
    vbeg(); w(ldi(4'd0, 8'hFF)); w(alu(4'h8, 4'd0, 4'd0)); w(outr(4'd0)); w(HLT);
    e(8'h00, 12'h100); vend(6, 8);
    // v3 multiply wrap
    vbeg(); w(ldi(4'd0, 8'h10)); w(ldi(4'd1, 8'h10)); w(alu(4'hA, 4'd0, 4'd1)); w(outr(4'd0)); w(HLT);
    e(8'h00, 12'h100); vend(8, 10);
    // v4 store/load round trip
    vbeg(); w(ldi(4'd2, 8'h5A)); w(st(4'd1, 4'd2)); w(ld(4'd1, 4'd3)); w(outr(4'd3)); w(HLT);
    e(8'h5A, 12'h05A); vend(8, 10);
    // v5 out-of-range register: r9 reads 0, and its write must not alias r1
    vbeg(); w(ldi(4'd1, 8'h33)); w(ldi(4'd9, 8'd7)); w(outr(4'd9)); w(outr(4'd1)); w(HLT);
    e(8'h00, 12'h000); e(8'h33, 12'h033); vend(6, 10);
    // v6 xor, shr, not, sub, reserved op, shl
    vbeg(); w(ldi(4'd0, 8'hC5)); w(ldi(4'd1, 8'h0F)); w(alu(4'h4, 4'd0, 4'd1)); w(outr(4'd0));
    w(alu(4'h6, 4'd0, 4'd0)); w(alu(4'h5, 4'd0, 4'd0)); w(outr(4'd0));
    w(alu(4'h1, 4'd1, 4'd0)); w(outr(4'd1)); w(alu(4'hC, 4'd1, 4'd0)); w(alu(4'h7, 4'd1, 4'd0));
    w(outr(4'd1)); w(HLT);
    e(8'hCA, 12'h0CA); e(8'h9A, 12'hF9A); e(8'h75, 12'h075); e(8'hEA, 12'h0EA); vend(8, 26);
    // v7 or, and, mov, jump target 0x18 wraps to 8
    vbeg(); w(ldi(4'd2, 8'h30)); w(ldi(4'd3, 8'h0C)); w(alu(4'h3, 4'd2, 4'd3)); w(outr(4'd2));
    w(alu(4'h2, 4'd2, 4'd3)); w(alu(4'hB, 4'd0, 4'd2)); w(jmp(8'h18)); w(outr(4'd3));
    w(outr(4'd0)); w(HLT);
    e(8'h3C, 12'h03C); e(8'h0C, 12'h00C); vend(8, 18);
    // v8 reads r2 before writing it, exposing register state left from before a reset
    vbeg(); w(outr(4'd2)); w(ldi(4'd2, 8'h44)); w(ldi(4'd0, 8'd3)); w(alu(4'h9, 4'd0, 4'd0));
    w(outr(4'd0)); w(jnz(4'd0, 8'd3)); w(HLT);
    e(8'h00, 12'h000); e(8'h02, 12'h002); e(8'h01, 12'h001); e(8'h00, 12'h000); vend(2, 26);

    for (int i = 0; i < nv; i++) begin
      do_reset();
      check_reset_state($sformatf("rst%0d", i));
      load_prog(i);
      run(1'b0);
      check_vec(i, $sformatf("v%0d", i));
    end

    // Reset mid-loop: program retained, registers cleared, rerun identical.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midrst");
    run(1'b0);
    check_vec(8, "midrst_rerun");

    // load_valid with start in the same cycle: load wins, core stays idle.
    do_reset();
    load_valid = 1'b1;
    start      = 1'b1;
    load_word  = wq[vt[0].pb];
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    chk("ldstart.busy", int'(busy8), 0);
    for (int k = 1; k < vt[0].pn; k++) begin
      load_valid = 1'b1;
      load_word  = wq[vt[0].pb + k];
      tick();
    end
    load_valid = 1'b0;
    run(1'b0);
    check_vec(0, "ldstart");

    // Loads attempted while running must not alter the program.
    run(1'b1);
    check_vec(0, "gate_run");
    run(1'b0);
    check_vec(0, "gate_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trash_cpu.md
# trash_cpu

Parametrised, programmable accumulator-style micro-CPU for the TinyTapeout tile. A host loads 16-bit instruction words into an internal program store, pulses `start`, and the core executes with a fetch/execute state machine. It operates on a configurable register file, data memory and ALU, and emits results on a registered output port with a valid strobe. It succeeds the first-generation fixed 8-bit core and adds configurable width and depth, a halt state, conditional branching, load gating while running, and defined out-of-range behaviour.

## Interface
- `DATA_W`, 8: register, memory and ALU width, from 8 to 16.
- `NREGS`, 4: register count, from 2 to 16.
- `PROG_DEPTH`, 16: program words; power of 2, from 2 to 256.
- `MEM_DEPTH`, 16: data memory words; power of 2, from 2 to 16.
- `clk` in 1: clock; all state on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `load_valid` in 1: write `load_word` to `program[load_addr]`.
- `load_word` in 16: instruction word.
- `start` in 1: begin execution at pc 0.
- `busy` out 1: high in FETCH or EXEC.
- `halted` out 1: high in HALT.
- `pc` out log2(PROG_DEPTH): current program counter.
- `out_data` out DATA_W: last OUT value, held.
- `out_valid` out 1: one-cycle strobe per OUT.

## Operation
- Instruction fields: [15:12] opcode, [11:8] A, [7:4] B, [3:0] C, [7:0] IMM.
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDI: r[A] <= IMM, zero-extended.
  - 0x2 ALU: r[B] <= alu(A, r[B], r[C]).
  - 0x3 ST: mem[A] <= r[C].
  - 0x4 LD: r[C] <= mem[A].
  - 0x5 JMP: pc <= IMM.
  - 0x6 JNZ: if r[A] != 0 then pc <= IMM, else pc+1.
  - 0x7 OUT: out_data <= r[A]; out_valid pulses.
  - 0x8 HALT.
  - 0x9–0xF behave as NOP.
- ALU ops, result truncated to DATA_W:
  - 0 add, 1 sub (mod 2^DATA_W), 2 and, 3 or, 4 xor.
  - 5 not x, 6 x>>1 (logical), 7 x<<1, 8 x+1, 9 x-1.
  - A mul (low DATA_W bits), B mov (y).
  - C–F leave r[B] unchanged.
  - x = r[B], y = r[C].
- Out-of-range register index (>= NREGS): read returns 0; write is dropped.
- Memory address = A mod MEM_DEPTH. Jump target = IMM mod PROG_DEPTH. pc+1 wraps at PROG_DEPTH.
- States:
  - IDLE: after reset.
  - IDLE or HALT + `start` -> FETCH with pc = 0 and load_addr = 0.
  - FETCH -> EXEC.
  - EXEC -> FETCH, or -> HALT on opcode 0x8.
  - HALT holds until `start`.
- Loading is accepted only in IDLE or HALT. load_addr increments after each write and wraps at PROG_DEPTH. `load_valid` in FETCH or EXEC is ignored.
- `load_valid` and `start` in the same cycle: the load is performed and `start` is ignored.
- Registers and data memory are not cleared by `start`.

## Timing
- Reset values: state IDLE; pc, load_addr, all registers, all data memory, `out_data` = 0; `busy`, `halted`, `out_valid` = 0. The program store is not reset, so contents are retained across `reset`.
- Reset asserted mid-run: takes effect at the next edge; `busy` = 0 in the following cycle.
- Start sampled at edge t:
  - Instruction k executes at edge t+2+2k (2 cycles per instruction, no pipelining).
  - OUT executing at edge e: `out_data` and `out_valid` are visible e+1 to e+2; `out_valid` is high for exactly that one cycle.
  - HALT executing at edge e: `halted` = 1 and `busy` = 0 from e+1.
- Program store is read synchronously in FETCH. Register and memory writes land at the EXEC edge and are visible to the next instruction.

## Structure
- `trash_pkg`: opcode localparams; ALU op localparams; field bit positions.
- `trash_alu`: combinational sub-module, parametrised by DATA_W, with inputs op, x, y and output res.
- FSM, register file, memories and load logic live in `trash_cpu`.

## Test plan
- Add: DATA_W=8. Program LDI r0,5; LDI r1,3; ALU add r0,r1; OUT r0; HALT; start at t -> `out_data` = 8 with a single `out_valid` at t+9; `halted` from t+11.
- Loop: LDI r0,3; ALU dec r0; OUT r0; JNZ r0,1; HALT -> OUT strobes 2, 1, 0, then halt.
- Width wrap:
  - DATA_W=8: LDI r0,0xFF; inc -> OUT 0x00. LDI 0x10 into r0 and r1; mul -> OUT 0x00.
  - DATA_W=12: same multiply -> OUT 0x100.
- Memory and range: MEM_DEPTH=16, NREGS=4.
  - LDI r2,0x5A; ST mem[1],r2; LD r3,mem[1]; OUT r3 -> 0x5A.
  - LDI r9,7; OUT r9 -> 0x00.
- Gating and reset:
  - `load_valid` during run -> program unchanged.
  - `reset` mid-loop -> `busy` = 0 next cycle, registers 0; `start` again reproduces the identical output sequence.
